// File: rtl/keycode_event_queue.sv
// Keycode level-to-event converter with optional typematic repeat, feeding a show-ahead FIFO.
// Define KEYQ_REPEAT_EN to build in auto-repeat; otherwise only press events are queued.
module keycode_event_queue #(
    parameter int KEY_W        = 8,
    parameter int DEPTH        = 8,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [KEY_W-1:0]         key_in,
    input  logic                     pop,
    input  logic                     flush,
    output logic [KEY_W-1:0]         key_out,
    output logic                     key_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_prev_q;
    logic             press;
    logic             rep_push;
    logic             push;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_q      <= '0;
            key_prev_q <= '0;
        end else begin
            key_q      <= key_in;
            key_prev_q <= key_q;
        end
    end

    assign press = (key_q != '0) && (key_q != key_prev_q);

`ifdef KEYQ_REPEAT_EN
    localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_ph_q, rep_ph_d;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rep_cnt_q <= '0;
            rep_ph_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_ph_q  <= rep_ph_d;
        end
    end

    // The terminal compare restarts the counter, so it never reaches its wrap point.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_ph_d  = rep_ph_q;
        rep_push  = 1'b0;
        if (press || (key_q == '0)) begin
            rep_cnt_d = '0;
            rep_ph_d  = 1'b0;
        end else if (!rep_ph_q) begin
            if (rep_cnt_q == CW'(REPEAT_DELAY - 1)) begin
                rep_push  = 1'b1;
                rep_cnt_d = '0;
                rep_ph_d  = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + CW'(1);
            end
        end else begin
            if (rep_cnt_q == CW'(REPEAT_RATE - 1)) begin
                rep_push  = 1'b1;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + CW'(1);
            end
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
    assign rep_push          = 1'b0;
`endif

    assign push = press | rep_push;

    logic [KEY_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             empty_w, full_w;
    logic             pop_ok, push_ok, wr_en;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop_ok  = pop && !empty_w;
    assign push_ok = push && (!full_w || pop_ok);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && full_w && !pop_ok) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= key_q;
        end
    end

    assign key_out   = empty_w ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign key_valid = !empty_w;
    assign count     = wr_ptr_q - rd_ptr_q;
    assign full      = full_w;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue (DEPTH=4, REPEAT_DELAY=10, REPEAT_RATE=4).
module tb_keycode_event_queue;
    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [7:0] key_in;
    logic       pop;
    logic       flush;
    logic [7:0] key_out;
    logic       key_valid;
    logic [2:0] count;
    logic       full;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    keycode_event_queue #(
        .KEY_W(8), .DEPTH(4), .REPEAT_DELAY(10), .REPEAT_RATE(4)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .key_in(key_in),
        .pop(pop), .flush(flush), .key_out(key_out), .key_valid(key_valid),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ko, input logic kv,
                             input logic [2:0] cnt, input logic fu, input logic ov);
        check({tag, ".key_out"},   32'(key_out),   32'(ko));
        check({tag, ".key_valid"}, 32'(key_valid), 32'(kv));
        check({tag, ".count"},     32'(count),     32'(cnt));
        check({tag, ".full"},      32'(full),      32'(fu));
        check({tag, ".overflow"},  32'(overflow),  32'(ov));
    endtask

    // Expected pushes for a held key, counted by edge offset from the first key_q update.
    function automatic int pushes_by(input int i);
        int n = 0;
`ifdef KEYQ_REPEAT_EN
        int t[6] = '{1, 11, 15, 19, 23, 27};
        for (int j = 0; j < 6; j++) if (t[j] <= i) n++;
`else
        if (i >= 1) n = 1;
`endif
        return n;
    endfunction

    initial begin
        int np;
        logic [7:0] exp_keys[4];
        reset_reset_n = 1'b0;
        key_in = 8'h00; pop = 1'b0; flush = 1'b0;
        repeat (3) tick();
        check_all("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        reset_reset_n = 1'b1;
        tick();

        // single press, 2-cycle latency, then pop
        key_in = 8'h04;
        tick();
        check("t1.latency1.valid", 32'(key_valid), 32'd0);
        tick();
        check_all("t1.after2", 8'h04, 1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        key_in = 8'h00;
        tick(); tick(); tick();
        check("t1.release.count", 32'(count), 32'd1);
        pop = 1'b1; tick(); pop = 1'b0;
        check_all("t1.popped", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

        // direct key-to-key change, then release
        key_in = 8'h04; tick(); tick();
        key_in = 8'h05; tick(); tick();
        key_in = 8'h00; tick(); tick(); tick();
        check_all("t2.two", 8'h04, 1'b1, 3'd2, 1'b0, 1'b0);
        pop = 1'b1; tick();
        check("t2.second.key", 32'(key_out), 32'h05);
        check("t2.second.count", 32'(count), 32'd1);
        tick();
        check("t2.drained.count", 32'(count), 32'd0);
        tick();
        check("t2.pop_empty.count", 32'(count), 32'd0);
        check("t2.pop_empty.valid", 32'(key_valid), 32'd0);
        pop = 1'b0;

        // held key with auto-repeat
        key_in = 8'h1A;
        for (int i = 0; i < 30; i++) begin
            tick();
            np = pushes_by(i);
            check($sformatf("t3.c%0d.count", i), 32'(count), 32'((np > 4) ? 4 : np));
            check($sformatf("t3.c%0d.full", i), 32'(full), 32'(np >= 4));
            check($sformatf("t3.c%0d.ovf", i), 32'(overflow), 32'(np >= 5));
        end
        key_in = 8'h00;
        tick(); tick();
        check("t3.end.key", 32'(key_out), 32'h1A);
`ifdef KEYQ_REPEAT_EN
        check_all("t3.end", 8'h1A, 1'b1, 3'd4, 1'b1, 1'b1);
`else
        check_all("t3.end", 8'h1A, 1'b1, 3'd1, 1'b0, 1'b0);
`endif

        // flush coincident with a press event
        key_in = 8'h22; tick();
        flush = 1'b1; tick(); flush = 1'b0;
        check_all("t5.flush", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        tick(); tick();
        check("t5.no_late_event", 32'(count), 32'd0);
        key_in = 8'h00; tick(); tick();

        // fill, then simultaneous push and pop while full
        key_in = 8'h11; tick();
        key_in = 8'h12; tick();
        key_in = 8'h13; tick();
        key_in = 8'h14; tick();
        key_in = 8'h00; tick(); tick();
        check_all("t4.filled", 8'h11, 1'b1, 3'd4, 1'b1, 1'b0);
        key_in = 8'h15; tick();
        pop = 1'b1; tick(); pop = 1'b0;
        check_all("t4.pushpop", 8'h12, 1'b1, 3'd4, 1'b1, 1'b0);
        key_in = 8'h00; tick();
        exp_keys = '{8'h12, 8'h13, 8'h14, 8'h15};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4.order%0d", i), 32'(key_out), 32'(exp_keys[i]));
            pop = 1'b1; tick(); pop = 1'b0;
        end
        check("t4.drained", 32'(count), 32'd0);

        // asynchronous reset while a key is held and two entries are queued
        key_in = 8'h2B; tick();
        key_in = 8'h2C; tick(); tick();
        check("t6.pre.count", 32'(count), 32'd2);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check_all("t6.async", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        tick(); tick();
        check_all("t6.held", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        reset_reset_n = 1'b1;
        tick();
        check("t6.rel1.valid", 32'(key_valid), 32'd0);
        tick();
        check_all("t6.rel2", 8'h2C, 1'b1, 3'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
